multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle sequencer for the core's shared datapath: one ALU and one unified instruction/data memory port, reused across instruction phases. Walks each instruction through FETCH, DECODE, EXEC, MEM and WB states, driving PC/IR/MDR enables, ALU operand selects, ALU_OP and register-file controls. Stalls on a memory ready handshake. Supports the existing opcode set: R-type, ADDI, SUBI, store and load.

## Interface
- No parameters. All encodings are fixed in the package.
- clk  in  1  clock; every transition occurs on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level enable; checked at instruction boundaries.
- OP  in  6  opcode from the IR; stable from DECODE until instruction end.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, ir_write, mdr_write  out  1  datapath register enables.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- mem_read, mem_write  out  1  memory strobes.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended immediate.
- ALU_OP  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- reg_write, reg_dst, mem2reg  out  1  register-file controls. reg_dst=1 selects rd. mem2reg=1 selects MDR.
- busy  out  1  high when the state is not IDLE.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.

## Operation
- State register is 3 bits: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Outputs are combinational from state, OP and mem_ready. Any output not listed for a state is 0.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ALU_OP=00.
  - If mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - If mem_ready=0: hold FETCH.
- DECODE: all outputs 0.
  - Legal opcode: go to EXEC.
  - Illegal opcode: see Configuration.
- EXEC: alu_src_a=1.
  - R-type: alu_src_b=00, ALU_OP=10, go to WB.
  - ADDI: alu_src_b=10, ALU_OP=00, go to WB.
  - SUBI: alu_src_b=10, ALU_OP=01, go to WB.
  - Load and store: alu_src_b=10, ALU_OP=00, go to MEM.
- MEM: iord=1, alu_src_a=1, alu_src_b=10, ALU_OP=00, so the address is held. Load drives mem_read=1; store drives mem_write=1.
  - Hold MEM while mem_ready=0.
  - Load with mem_ready=1: mdr_write=1, go to WB.
  - Store with mem_ready=1: instr_done=1, end of instruction.
- WB: reg_write=1 and instr_done=1.
  - reg_dst=1 for R-type, else 0.
  - mem2reg=1 for load, else 0.
  - End of instruction.
- End of instruction: go to FETCH if run=1, else IDLE.
- run=0 mid-instruction does not abort; the instruction completes.

## Timing
- Reset: state=IDLE. Every output, including busy, is 0 immediately (asynchronously), so no strobe can persist into reset.
- Latency with mem_ready tied high:
  - R-type, ADDI, SUBI, store: 4 cycles.
  - Load: 5 cycles.
- Each low cycle of mem_ready in FETCH or MEM adds exactly 1 cycle.
- mem_read and mem_write are never both 1.
- reg_write and mem_write are never both 1.
- pc_write fires exactly once per instruction.
- instr_done goes high exactly once per completed instruction.
- Back-to-back: the cycle after instr_done is FETCH when run=1.
- Reset asserted mid-MEM: mem_write drops in the same cycle, with no partial write and no pending state. After release: IDLE.

## Configuration
- MC_CTRL_ILLEGAL_TRAP_EN
  - Defined: an illegal opcode in DECODE goes to TRAP. Output illegal_op (1 bit, port present only when defined) is 1 in TRAP. TRAP holds with all other outputs 0 until rst_n. run is ignored in TRAP.
  - Undefined: an illegal opcode is a NOP. DECODE pulses instr_done=1 and then follows the end-of-instruction rule. State TRAP is unreachable.

## Structure
- Package mc_ctrl_pkg holds:
  - Opcode constants: OP_RTYPE=6'b000000, OP_ADDI=6'b001100, OP_SUBI=6'b001101, OP_SW=6'b010000, OP_LW=6'b010001.
  - ALU_OP encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT.
  - alu_src_b encodings.
  - State enum.
- Sub-module mc_ctrl_opclass: purely combinational. Maps OP to one-hot class flags is_r, is_imm, is_ld, is_st, is_illegal. The FSM consumes these flags.

## Test plan
- ADDI, mem_ready=1, run=1: states 1→2→3→5. In EXEC: alu_src_b=10, ALU_OP=00. In WB: reg_write=1, reg_dst=0, instr_done=1. Next cycle: FETCH.
- Load with mem_ready low for 2 cycles in MEM: latency is 7 cycles. mdr_write=1 only in the ready cycle. WB has mem2reg=1.
- Store: MEM asserts mem_write=1 and iord=1, with reg_write never 1. instr_done fires in the MEM ready cycle. Total 4 cycles.
- rst_n=0 during a store's MEM cycle: mem_write and busy go to 0 asynchronously. After release: IDLE, and FETCH starts only when run=1.
- run deasserted during an R-type EXEC: WB completes with reg_dst=1, then the state goes to IDLE and busy=0.
- OP=6'b111111: with MC_CTRL_ILLEGAL_TRAP_EN, TRAP is held and illegal_op=1. Without it, a 2-cycle NOP with instr_done pulsed in DECODE.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: opcodes, ALU controls, operand selects, states.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001100;
    localparam logic [5:0] OP_SUBI  = 6'b001101;
    localparam logic [5:0] OP_SW    = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b010001;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

endpackage

// File: rtl/mc_ctrl_opclass.sv
// Combinational opcode classifier: one-hot class flags consumed by the sequencer FSM.
module mc_ctrl_opclass
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output logic       is_r,
    output logic       is_imm,
    output logic       is_ld,
    output logic       is_st,
    output logic       is_illegal
);

    assign is_r       = (op == OP_RTYPE);
    assign is_imm     = (op == OP_ADDI) || (op == OP_SUBI);
    assign is_ld      = (op == OP_LW);
    assign is_st      = (op == OP_SW);
    assign is_illegal = !(is_r || is_imm || is_ld || is_st);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a shared ALU and memory port.
// Optional build macro MC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes lock into TRAP and raise illegal_op.
//
// state  | meaning
// IDLE   | waiting for run at an instruction boundary
// FETCH  | read instruction at PC, PC += 4 on mem_ready
// DECODE | classify opcode (illegal: NOP or TRAP)
// EXEC   | ALU computes result or effective address
// MEM    | load/store access at ALU address, stalls on mem_ready
// WB     | register-file write, instruction ends
// TRAP   | illegal opcode lock-up until reset
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] OP,
    input  logic       mem_ready,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    output logic       illegal_op,
`endif
    output logic       pc_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALU_OP,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem2reg,
    output logic       busy,
    output logic       instr_done
);

    state_t state, state_next;
    logic   is_r, is_imm, is_ld, is_st, is_illegal;

    mc_ctrl_opclass u_opclass (
        .op         (OP),
        .is_r       (is_r),
        .is_imm     (is_imm),
        .is_ld      (is_ld),
        .is_st      (is_st),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Outputs decode straight from state, so an async reset clears every strobe at once.
    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mdr_write  = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        ALU_OP     = ALUOP_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem2reg    = 1'b0;
        instr_done = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal_op = 1'b0;
`endif
        busy       = (state != S_IDLE) && (state != S_TRAP);

        case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    state_next = S_TRAP;
`else
                    instr_done = 1'b1;
                    state_next = run ? S_FETCH : S_IDLE;
`endif
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                if (is_r) begin
                    alu_src_b  = SRCB_RT;
                    ALU_OP     = ALUOP_FUNCT;
                    state_next = S_WB;
                end else if (is_imm) begin
                    alu_src_b  = SRCB_IMM;
                    ALU_OP     = (OP == OP_SUBI) ? ALUOP_SUB : ALUOP_ADD;
                    state_next = S_WB;
                end else begin
                    alu_src_b  = SRCB_IMM;
                    ALU_OP     = ALUOP_ADD;
                    state_next = S_MEM;
                end
            end
            S_MEM: begin
                iord      = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ALU_OP    = ALUOP_ADD;
                mem_read  = is_ld;
                mem_write = !is_ld;
                if (mem_ready) begin
                    if (is_ld) begin
                        mdr_write  = 1'b1;
                        state_next = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_next = run ? S_FETCH : S_IDLE;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                reg_dst    = is_r;
                mem2reg    = is_ld;
                state_next = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                illegal_op = 1'b1;
                state_next = S_TRAP;
`else
                state_next = S_IDLE;
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
